// File: rtl/systolic_feeder.sv
// Input-side sequencer for a SIZE x SIZE systolic MAC array: captures A/B on start,
// then emits CLEAR, skewed FEED beats, DRAIN and a one-cycle DONE (3*SIZE+DRAIN_CYCLES cycles start-to-done).
// No backpressure: start is taken only while ready (IDLE); starts at any other time are dropped, not queued.
//
// Ports:
//   clk, reset (sync, active-low), start         - control inputs
//   a_mat[row][col], b_mat[row][col]              - operand matrices, sampled on the accepting edge
//   ready, done                                   - handshake / completion pulse
//   a_stream[row], b_stream[col]                  - array edge inputs (row-skewed A, column-skewed B)
//   load_en, mult_en, acc_en                      - array controls (clear, multiply, accumulate)
module systolic_feeder #(
    parameter int SIZE         = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a_mat [0:SIZE-1][0:SIZE-1],
    input  logic [7:0] b_mat [0:SIZE-1][0:SIZE-1],
    output logic       ready,
    output logic       done,
    output logic [7:0] a_stream [0:SIZE-1],
    output logic [7:0] b_stream [0:SIZE-1],
    output logic       load_en,
    output logic       mult_en,
    output logic       acc_en
);

    localparam int CW = $clog2(3 * SIZE + DRAIN_CYCLES);
    localparam logic [CW-1:0] FEED_LAST  = CW'(3 * SIZE - 3);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;

    logic [7:0]    a_reg [0:SIZE-1][0:SIZE-1];
    logic [7:0]    b_reg [0:SIZE-1][0:SIZE-1];
    logic [7:0]    a_nxt [0:SIZE-1];
    logic [7:0]    b_nxt [0:SIZE-1];

    assign accept = (state == IDLE) && start;

    // State register and beat counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state. The counter only advances inside FEED/DRAIN and is zeroed on
    // every transition, so each state sees it start from 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = FEED;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stream lanes for the upcoming beat. Lane i carries element k when the
    // beat equals i+k, which delays row i of A (and column i of B) by i beats.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_nxt[i] = '0;
            b_nxt[i] = '0;
            if (state_nxt == FEED) begin
                for (int k = 0; k < SIZE; k++) begin
                    if (int'(cnt_nxt) == i + k) begin
                        a_nxt[i] = a_reg[i][k];
                        b_nxt[i] = b_reg[k][i];
                    end
                end
            end
        end
    end

    // Operand capture and registered outputs. Outputs are decoded from the next
    // state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                end
                a_stream[i] <= '0;
                b_stream[i] <= '0;
            end
            ready   <= 1'b1;
            done    <= 1'b0;
            load_en <= 1'b0;
            mult_en <= 1'b0;
            acc_en  <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        a_reg[i][j] <= a_mat[i][j];
                        b_reg[i][j] <= b_mat[i][j];
                    end
                end
            end
            for (int i = 0; i < SIZE; i++) begin
                a_stream[i] <= a_nxt[i];
                b_stream[i] <= b_nxt[i];
            end
            ready   <= (state_nxt == IDLE);
            done    <= (state_nxt == DONE);
            load_en <= (state_nxt == CLEAR);
            mult_en <= (state_nxt == FEED);
            acc_en  <= (state_nxt == FEED) || (state_nxt == DRAIN);
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

    logic clk;
    logic reset;
    logic start;
    logic start2;

    logic [7:0] a_mat [0:3][0:3];
    logic [7:0] b_mat [0:3][0:3];
    logic       ready, done, load_en, mult_en, acc_en;
    logic [7:0] a_stream [0:3];
    logic [7:0] b_stream [0:3];

    logic [7:0] a2_mat [0:1][0:1];
    logic [7:0] b2_mat [0:1][0:1];
    logic       ready2, done2, load_en2, mult_en2, acc_en2;
    logic [7:0] a2_stream [0:1];
    logic [7:0] b2_stream [0:1];

    int checks;
    int failures;

    // Behavioural 4x4 systolic array driven by u_dut's outputs.
    int acc [0:3][0:3];
    int ap  [0:3][0:3];
    int bp  [0:3][0:3];

    systolic_feeder #(.SIZE(4), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .a_mat(a_mat), .b_mat(b_mat),
        .ready(ready), .done(done),
        .a_stream(a_stream), .b_stream(b_stream),
        .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en)
    );

    systolic_feeder #(.SIZE(2), .DRAIN_CYCLES(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .a_mat(a2_mat), .b_mat(b2_mat),
        .ready(ready2), .done(done2),
        .a_stream(a2_stream), .b_stream(b2_stream),
        .load_en(load_en2), .mult_en(mult_en2), .acc_en(acc_en2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One array clock edge, using the feeder outputs visible in this cycle.
    task automatic model_step();
        int na [0:3][0:3];
        int nb [0:3][0:3];
        int ain;
        int bin;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0) ain = int'(a_stream[i]);
                else        ain = ap[i][j-1];
                if (i == 0) bin = int'(b_stream[j]);
                else        bin = bp[i-1][j];
                if (load_en)                acc[i][j] = 0;
                else if (mult_en && acc_en) acc[i][j] = acc[i][j] + ain * bin;
                na[i][j] = ain;
                nb[i][j] = bin;
            end
        end
        ap = na;
        bp = nb;
    endtask

    // Advance to the next negedge: outputs seen afterwards are those the
    // array samples on the coming rising edge.
    task automatic nc();
        @(negedge clk);
        model_step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        nc();
        nc();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if ({load_en, mult_en, acc_en} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {load_en, mult_en, acc_en}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_stream[i] !== 8'd0 || b_stream[i] !== 8'd0) begin failures++; $display("FAIL rst_stream lane=%0d got=%0d/%0d exp=0/0", i, a_stream[i], b_stream[i]); end
        end
        checks++; if (ready2 !== 1'b1 || done2 !== 1'b0) begin failures++; $display("FAIL rst_dut2 got=%b%b exp=10", ready2, done2); end
        reset = 1'b1;
        nc();
    endtask

    task automatic test_identity();
        int t;
        logic feed;
        logic [7:0] ea;
        logic [7:0] eb;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_mat[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_mat[i][j] = 8'(4 * i + j);
            end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL id_ready_pre got=%b exp=1", ready); end
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            nc();
            start = 1'b0;
            t = c - 2;
            feed = (c >= 2 && c <= 11);
            for (int i = 0; i < 4; i++) begin
                ea = 8'd0;
                eb = 8'd0;
                if (feed && t - i >= 0 && t - i < 4) begin
                    ea = (t - i == i) ? 8'd1 : 8'd0;
                    eb = 8'(4 * (t - i) + i);
                end
                checks++; if (a_stream[i] !== ea) begin failures++; $display("FAIL id_a_stream c=%0d lane=%0d got=%0d exp=%0d", c, i, a_stream[i], ea); end
                checks++; if (b_stream[i] !== eb) begin failures++; $display("FAIL id_b_stream c=%0d lane=%0d got=%0d exp=%0d", c, i, b_stream[i], eb); end
            end
            checks++; if (load_en !== (c == 1)) begin failures++; $display("FAIL id_load c=%0d got=%b", c, load_en); end
            checks++; if (mult_en !== feed) begin failures++; $display("FAIL id_mult c=%0d got=%b exp=%b", c, mult_en, feed); end
            checks++; if (acc_en !== (c >= 2 && c <= 13)) begin failures++; $display("FAIL id_acc c=%0d got=%b", c, acc_en); end
            checks++; if (done !== (c == 14)) begin failures++; $display("FAIL id_done c=%0d got=%b", c, done); end
            checks++; if (ready !== (c >= 15)) begin failures++; $display("FAIL id_ready c=%0d got=%b", c, ready); end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++; if (acc[i][j] !== 4 * i + j) begin failures++; $display("FAIL id_out [%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], 4 * i + j); end
            end
    endtask

    task automatic test_saturate();
        int mult_cnt;
        int load_cnt;
        int first_load;
        int first_mult;
        mult_cnt = 0; load_cnt = 0; first_load = -1; first_mult = -1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_mat[i][j] = 8'd255;
                b_mat[i][j] = 8'd255;
            end
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            nc();
            start = 1'b0;
            if (mult_en) begin mult_cnt++; if (first_mult < 0) first_mult = c; end
            if (load_en) begin load_cnt++; if (first_load < 0) first_load = c; end
        end
        checks++; if (mult_cnt !== 10) begin failures++; $display("FAIL sat_mult_cycles got=%0d exp=10", mult_cnt); end
        checks++; if (load_cnt !== 1) begin failures++; $display("FAIL sat_load_cycles got=%0d exp=1", load_cnt); end
        checks++; if (first_load !== 1 || first_mult !== 2) begin failures++; $display("FAIL sat_load_order got=load@%0d mult@%0d exp=load@1 mult@2", first_load, first_mult); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++; if (acc[i][j] !== 260100) begin failures++; $display("FAIL sat_out [%0d][%0d] got=%0d exp=260100", i, j, acc[i][j]); end
            end
    endtask

    task automatic test_ignored_start();
        int done_cnt;
        int load_cnt;
        done_cnt = 0; load_cnt = 0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            nc();
            if (done) done_cnt++;
            if (load_en) load_cnt++;
            checks++; if (ready !== (c >= 15)) begin failures++; $display("FAIL ign_ready c=%0d got=%b exp=%b", c, ready, (c >= 15)); end
            start = (c == 3 || c == 9 || c == 14);
        end
        start = 1'b0;
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
        checks++; if (load_cnt !== 1) begin failures++; $display("FAIL ign_runs got=%0d exp=1", load_cnt); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_mat[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_mat[i][j] = 8'(4 * i + j);
            end
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            nc();
            start = 1'b0;
        end
        // Cycle 6 shows beat 4: lane 0 carries nothing, lane 2 carries B[2][2].
        checks++; if (mult_en !== 1'b1 || b_stream[2] !== 8'd10) begin failures++; $display("FAIL rm_beat4 got=mult %b b2 %0d exp=mult 1 b2 10", mult_en, b_stream[2]); end
        reset = 1'b0;
        nc();
        reset = 1'b1;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rm_handshake got=%b%b exp=10", ready, done); end
        checks++; if ({load_en, mult_en, acc_en} !== 3'b000) begin failures++; $display("FAIL rm_ctrl got=%b exp=000", {load_en, mult_en, acc_en}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_stream[i] !== 8'd0 || b_stream[i] !== 8'd0) begin failures++; $display("FAIL rm_stream lane=%0d got=%0d/%0d exp=0/0", i, a_stream[i], b_stream[i]); end
        end
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            nc();
            if (done) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", done_cnt); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a_mat[i][j] = (i == j) ? 8'd2 : 8'd0;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            nc();
            start = 1'b0;
            if (done) done_cnt++;
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rm_rerun_done got=%0d exp=1", done_cnt); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++; if (acc[i][j] !== 2 * (4 * i + j)) begin failures++; $display("FAIL rm_out [%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], 2 * (4 * i + j)); end
            end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_mat[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_mat[i][j] = 8'(4 * i + j);
            end
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            nc();
            checks++; if (done !== (c == 14 || c == 29)) begin failures++; $display("FAIL b2b_done c=%0d got=%b", c, done); end
            if (c == 5) begin
                // Second operand set: A2[r][c] = r+1, B2 = identity.
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        a_mat[i][j] = 8'(i + 1);
                        b_mat[i][j] = (i == j) ? 8'd1 : 8'd0;
                    end
            end
            if (c == 15) begin
                checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready15 got=%b exp=1", ready); end
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        checks++; if (acc[i][j] !== 4 * i + j) begin failures++; $display("FAIL b2b_run1 [%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], 4 * i + j); end
                    end
            end
            if (c == 16) begin
                checks++; if (load_en !== 1'b1) begin failures++; $display("FAIL b2b_clear16 got=%b exp=1", load_en); end
                start = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++; if (acc[i][j] !== i + 1) begin failures++; $display("FAIL b2b_run2 [%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], i + 1); end
            end
    endtask

    task automatic test_size2();
        int mult_cnt;
        mult_cnt = 0;
        a2_mat[0][0] = 8'd1; a2_mat[0][1] = 8'd2; a2_mat[1][0] = 8'd3; a2_mat[1][1] = 8'd4;
        b2_mat[0][0] = 8'd5; b2_mat[0][1] = 8'd6; b2_mat[1][0] = 8'd7; b2_mat[1][1] = 8'd8;
        start2 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            nc();
            start2 = 1'b0;
            if (mult_en2) mult_cnt++;
            checks++; if (mult_en2 !== (c >= 2 && c <= 5)) begin failures++; $display("FAIL s2_mult c=%0d got=%b", c, mult_en2); end
            checks++; if (acc_en2 !== (c >= 2 && c <= 6)) begin failures++; $display("FAIL s2_acc c=%0d got=%b", c, acc_en2); end
            checks++; if (done2 !== (c == 7)) begin failures++; $display("FAIL s2_done c=%0d got=%b", c, done2); end
            if (c == 2) begin
                checks++; if (a2_stream[1] !== 8'd0) begin failures++; $display("FAIL s2_a1_beat0 got=%0d exp=0", a2_stream[1]); end
                checks++; if (a2_stream[0] !== 8'd1 || b2_stream[0] !== 8'd5) begin failures++; $display("FAIL s2_beat0_lane0 got=%0d/%0d exp=1/5", a2_stream[0], b2_stream[0]); end
            end
            if (c == 3) begin
                checks++; if (a2_stream[1] !== 8'd3 || b2_stream[1] !== 8'd6) begin failures++; $display("FAIL s2_beat1_lane1 got=%0d/%0d exp=3/6", a2_stream[1], b2_stream[1]); end
            end
            if (c == 4) begin
                checks++; if (a2_stream[1] !== 8'd4 || b2_stream[1] !== 8'd8) begin failures++; $display("FAIL s2_beat2_lane1 got=%0d/%0d exp=4/8", a2_stream[1], b2_stream[1]); end
            end
            if (c == 5) begin
                checks++; if (a2_stream[1] !== 8'd0 || a2_stream[0] !== 8'd0 || b2_stream[1] !== 8'd0) begin failures++; $display("FAIL s2_beat3 got=%0d/%0d/%0d exp=0/0/0", a2_stream[1], a2_stream[0], b2_stream[1]); end
            end
        end
        checks++; if (mult_cnt !== 4) begin failures++; $display("FAIL s2_feed_beats got=%0d exp=4", mult_cnt); end
        checks++; if (ready2 !== 1'b1) begin failures++; $display("FAIL s2_ready_end got=%b exp=1", ready2); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a_mat[i][j] = 8'd0;
                b_mat[i][j] = 8'd0;
                acc[i][j]   = 0;
                ap[i][j]    = 0;
                bp[i][j]    = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a2_mat[i][j] = 8'd0;
                b2_mat[i][j] = 8'd0;
            end
        end
        test_reset();
        test_identity();
        test_saturate();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_size2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
